gamepad_pmod_serializer: RTL and testbench

- Emulates the Gamepad Pmod controller side. Takes a parallel button word and drives the serial pmod_data / pmod_clk / pmod_latch protocol that gamepad_pmod_driver receives.
- Sits directly upstream of gamepad_pmod_single / gamepad_pmod_dual.
- Used for on-chip loopback self-test and for driving the gamepad input path from an internal source, such as a demo-mode sequencer.
- Accepts one frame per valid/ready handshake.

---
 rtl/gamepad_pmod_serializer.sv | 180 ++++++++++++++++++
 tb/tb_gamepad_pmod_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_serializer.sv
// ============================================================================
// gamepad_pmod_serializer
//
// Controller-side emulation of the Gamepad Pmod. A parallel button word is
// accepted on a valid/ready handshake and shifted out MSB first on
// pmod_data/pmod_clk. A pmod_latch pulse follows the last bit; the receiver
// transfers its shift register on the latch rising edge. Feeds
// gamepad_pmod_single / gamepad_pmod_dual for loopback self-test or for
// driving the gamepad input path from an internal source.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   frame_data   in   [BIT_WIDTH] button word, 1 = pressed, MSB sent first
//   frame_valid  in   frame_data valid
//   frame_ready  out  idle and able to accept a frame
//   frame_done   out  one-cycle pulse when a frame's latch completes
//   pmod_data    out  serial data, stable across the whole pmod_clk high phase
//   pmod_clk     out  serial clock, receiver samples on the rising edge
//   pmod_latch   out  latch, receiver transfers on the rising edge
//
// Parameters:
//   BIT_WIDTH     bits per frame (12 for one controller, 24 for two)
//   HALF_PERIOD   system clocks per pmod_clk half-period, 3..255
//   LATCH_CYCLES  system clocks pmod_latch is held high, 3..255
//
// All outputs are registered; their next values are derived from the
// next FSM state so every output changes on the same edge as the state.
// ============================================================================
module gamepad_pmod_serializer #(
   parameter int BIT_WIDTH    = 12,
   parameter int HALF_PERIOD  = 4,
   parameter int LATCH_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_WIDTH-1:0] frame_data,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   output logic                 frame_done,
   output logic                 pmod_data,
   output logic                 pmod_clk,
   output logic                 pmod_latch
);

   localparam int BC_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   localparam logic [BC_W-1:0] BIT_RELOAD   = BC_W'(BIT_WIDTH - 1);
   localparam logic [7:0]      PHASE_RELOAD = 8'(HALF_PERIOD - 1);
   localparam logic [7:0]      LATCH_RELOAD = 8'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLK_LO = 2'd1,
      CLK_HI = 2'd2,
      LATCH  = 2'd3
   } state_e;

   state_e                 state_q,     state_d;
   logic [BIT_WIDTH-1:0]   shift_q,     shift_d;
   logic [BC_W-1:0]        bit_cnt_q,   bit_cnt_d;
   logic [7:0]             phase_cnt_q, phase_cnt_d;
   logic [7:0]             latch_cnt_q, latch_cnt_d;

   logic                   frame_ready_q, frame_ready_d;
   logic                   frame_done_q,  frame_done_d;
   logic                   pmod_data_q,   pmod_data_d;
   logic                   pmod_clk_q,    pmod_clk_d;
   logic                   pmod_latch_q,  pmod_latch_d;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         phase_cnt_q   <= '0;
         latch_cnt_q   <= '0;
         frame_ready_q <= 1'b1;
         frame_done_q  <= 1'b0;
         pmod_data_q   <= 1'b0;
         pmod_clk_q    <= 1'b0;
         pmod_latch_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         phase_cnt_q   <= phase_cnt_d;
         latch_cnt_q   <= latch_cnt_d;
         frame_ready_q <= frame_ready_d;
         frame_done_q  <= frame_done_d;
         pmod_data_q   <= pmod_data_d;
         pmod_clk_q    <= pmod_clk_d;
         pmod_latch_q  <= pmod_latch_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      phase_cnt_d  = phase_cnt_q;
      latch_cnt_d  = latch_cnt_q;
      frame_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            // The word is captured only here; frame_data is ignored while busy.
            if (frame_valid && frame_ready_q) begin
               shift_d     = frame_data;
               bit_cnt_d   = BIT_RELOAD;
               phase_cnt_d = PHASE_RELOAD;
               state_d     = CLK_LO;
            end
         end

         CLK_LO: begin
            if (phase_cnt_q == 8'd0) begin
               phase_cnt_d = PHASE_RELOAD;
               state_d     = CLK_HI;
            end else begin
               phase_cnt_d = phase_cnt_q - 8'd1;
            end
         end

         CLK_HI: begin
            if (phase_cnt_q == 8'd0) begin
               shift_d     = {shift_q[BIT_WIDTH-2:0], 1'b0};
               phase_cnt_d = PHASE_RELOAD;
               if (bit_cnt_q == '0) begin
                  latch_cnt_d = LATCH_RELOAD;
                  state_d     = LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  state_d   = CLK_LO;
               end
            end else begin
               phase_cnt_d = phase_cnt_q - 8'd1;
            end
         end

         LATCH: begin
            if (latch_cnt_q == 8'd0) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end else begin
               latch_cnt_d = latch_cnt_q - 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Returning to IDLE through the done cycle guarantees pmod_latch is low
      // for at least one cycle before a back-to-back frame's first CLK_LO.
      frame_ready_d = (state_d == IDLE);
      pmod_clk_d    = (state_d == CLK_HI);
      pmod_latch_d  = (state_d == LATCH);

      // Data follows the (possibly just shifted) MSB in CLK_LO and is frozen
      // across CLK_HI so the receiver's synchronised sample is stable.
      case (state_d)
         CLK_LO:  pmod_data_d = shift_d[BIT_WIDTH-1];
         CLK_HI:  pmod_data_d = pmod_data_q;
         default: pmod_data_d = 1'b0;
      endcase
   end

   assign frame_ready = frame_ready_q;
   assign frame_done  = frame_done_q;
   assign pmod_data   = pmod_data_q;
   assign pmod_clk    = pmod_clk_q;
   assign pmod_latch  = pmod_latch_q;

endmodule

// File: tb/tb_gamepad_pmod_serializer.sv
// ============================================================================
// tb_gamepad_pmod_serializer
//
// Scoreboard bench. The stimulus process pushes each accepted word and its
// acceptance edge into queues. An independent monitor decodes the serial
// stream the way a receiver would (shift on pmod_clk rising, transfer on
// pmod_latch rising) and, on every frame_done, pops the expected entry and
// compares the recovered word and the protocol timing, which is computed
// from the frame length formulas rather than from any FSM detail.
// ============================================================================
module tb_gamepad_pmod_serializer;

   localparam int BW    = 12;
   localparam int HP    = 4;
   localparam int LC    = 4;
   localparam int TOTAL = 2 * HP * BW + LC;   // acceptance edge -> done sample

   logic          clk;
   logic          rst_n;
   logic [BW-1:0] frame_data;
   logic          frame_valid;
   logic          frame_ready;
   logic          frame_done;
   logic          pmod_data;
   logic          pmod_clk;
   logic          pmod_latch;

   gamepad_pmod_serializer #(
      .BIT_WIDTH    (BW),
      .HALF_PERIOD  (HP),
      .LATCH_CYCLES (LC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_done  (frame_done),
      .pmod_data   (pmod_data),
      .pmod_clk    (pmod_clk),
      .pmod_latch  (pmod_latch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Scoreboard queues: expected word and its acceptance edge
   logic [BW-1:0] exp_q[$];
   int            t0_q[$];

   // Monitor state
   logic          prev_clk   = 1'b0;
   logic          prev_latch = 1'b0;
   logic [BW-1:0] rx_word    = '0;
   int            rx_cnt     = 0;
   int            first_rise = 0;
   int            latch_start = 0;
   int            latch_len  = 0;
   logic [BW-1:0] latched_word = '0;
   int            latched_cnt = 0;
   int            ready_bad  = 0;
   int            idle_bad   = 0;
   int            clk_rises  = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_clk   = 1'b0;
         prev_latch = 1'b0;
         rx_cnt     = 0;
         rx_word    = '0;
         latch_len  = 0;
         ready_bad  = 0;
         exp_q.delete();
         t0_q.delete();
      end else begin
         if (frame_ready && (pmod_clk || pmod_latch || pmod_data))
            idle_bad++;
         if (t0_q.size() > 0 && frame_ready &&
             edge_n >= t0_q[0] && edge_n < t0_q[0] + TOTAL)
            ready_bad++;
         if (pmod_clk && !prev_clk) begin
            clk_rises++;
            if (rx_cnt == 0) first_rise = edge_n;
            rx_word = {rx_word[BW-2:0], pmod_data};
            rx_cnt++;
         end
         if (pmod_latch && !prev_latch) begin
            latch_start  = edge_n;
            latched_word = rx_word;
            latched_cnt  = rx_cnt;
            latch_len    = 0;
            rx_cnt       = 0;
         end
         if (pmod_latch) latch_len++;
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               logic [BW-1:0] w;
               int            t0;
               w  = exp_q.pop_front();
               t0 = t0_q.pop_front();
               chk("word",        int'(latched_word), int'(w));
               chk("bit_count",   latched_cnt, BW);
               chk("first_rise",  first_rise, t0 + HP);
               chk("latch_start", latch_start, t0 + 2 * HP * BW);
               chk("latch_len",   latch_len, LC);
               chk("done_time",   edge_n, t0 + TOTAL);
               chk("ready_low",   ready_bad, 0);
               ready_bad = 0;
            end
         end
         prev_clk   = pmod_clk;
         prev_latch = pmod_latch;
      end
   end

   // Called at a negedge; leaves frame_valid asserted until acceptance.
   task automatic accept(input logic [BW-1:0] w, output int t0);
      int budget = 0;
      frame_data  = w;
      frame_valid = 1'b1;
      while (!frame_ready && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      t0 = edge_n + 1;
      if (!frame_ready) begin
         chk("accept_timeout", 0, 1);
         frame_valid = 1'b0;
         return;
      end
      exp_q.push_back(w);
      t0_q.push_back(t0);
      @(negedge clk);
   endtask

   // Scrambles the inputs while busy; returns at the negedge where ready is back.
   task automatic drain_busy();
      int budget = 0;
      while (!frame_ready && budget < 400) begin
         frame_data  = BW'($urandom);
         frame_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         budget++;
      end
      if (!frame_ready) chk("busy_timeout", 0, 1);
      frame_valid = 1'b0;
   endtask

   initial begin
      int t0a, t0b, rises0, budget;
      logic [BW-1:0] directed [5];
      directed[0] = 12'hA05;
      directed[1] = 12'b000000010000;
      directed[2] = 12'hFFF;
      directed[3] = 12'h000;
      directed[4] = 12'h5A5;

      rst_n       = 1'b1;
      frame_valid = 1'b0;
      frame_data  = '0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_data",  int'(pmod_data),   0);
      chk("rst_clk",   int'(pmod_clk),    0);
      chk("rst_latch", int'(pmod_latch),  0);
      chk("rst_ready", int'(frame_ready), 1);
      chk("rst_done",  int'(frame_done),  0);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b1;

      // Idle with no valid: no serial activity, ready stays high
      rises0 = clk_rises;
      repeat (200) @(negedge clk);
      chk("idle_no_clk", clk_rises - rises0, 0);
      chk("idle_ready",  int'(frame_ready), 1);

      // Directed frames, each followed by an idle gap
      foreach (directed[i]) begin
         accept(directed[i], t0a);
         drain_busy();
         repeat (3) @(negedge clk);
      end

      // Back-to-back: second acceptance lands in the done cycle
      accept(12'h001, t0a);
      drain_busy();
      accept(12'h800, t0b);
      chk("b2b_accept", t0b, t0a + TOTAL + 1);
      drain_busy();
      repeat (3) @(negedge clk);

      // Mid-frame reset after the 6th pmod_clk rising edge
      accept(12'h3C3, t0a);
      frame_valid = 1'b0;
      budget = 0;
      do begin
         @(negedge clk);
         #1;
         budget++;
      end while (rx_cnt < 6 && budget < 400);
      chk("midrst_reach6", rx_cnt, 6);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_data",  int'(pmod_data),   0);
      chk("midrst_clk",   int'(pmod_clk),    0);
      chk("midrst_latch", int'(pmod_latch),  0);
      chk("midrst_ready", int'(frame_ready), 1);
      chk("midrst_done",  int'(frame_done),  0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      accept(12'h6B9, t0a);
      drain_busy();

      // Randomized frames with random gaps (gap 0 = back-to-back)
      for (int n = 0; n < 20; n++) begin
         accept(BW'($urandom), t0a);
         drain_busy();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      budget = 0;
      while (exp_q.size() > 0 && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      chk("drain_queue", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      chk("idle_outputs", idle_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
